// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with optional start/stop framing
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FRAME     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  output logic             ready,
  output logic             busy,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Capture ignores ce so a word is never lost waiting for a bit tick.
        if (load) begin
          shreg_nxt = pin;
          cnt_nxt   = '0;
          state_nxt = FRAME ? START : DATA;
        end
      end
      START: begin
        if (ce) state_nxt = DATA;
      end
      DATA: begin
        if (ce) begin
          shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = FRAME ? STOP : IDLE;
            done_nxt  = !FRAME;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      STOP: begin
        if (ce) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    so = 1'b1;
    case (state)
      START:   so = 1'b0;
      DATA:    so = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      default: so = 1'b1;
    endcase
  end

  assign ready    = (state == IDLE);
  assign busy     = (state != IDLE);
  assign so_valid = (state == DATA);

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - scoreboard bench for piso_tx (framed MSB-first and unframed LSB-first)
module tb_piso_tx;

  localparam int W = 4;

  typedef struct packed {
    logic so;
    logic vld;
    logic done;
    logic busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, ce, load, load_b;
  logic [W-1:0] pin;
  logic         a_ready, a_busy, a_so, a_vld, a_done;
  logic         b_ready, b_busy, b_so, b_vld, b_done;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .FRAME(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .pin(pin),
    .ready(a_ready), .busy(a_busy), .so(a_so), .so_valid(a_vld), .done(a_done)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .FRAME(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .load(load_b), .pin(pin),
    .ready(b_ready), .busy(b_busy), .so(b_so), .so_valid(b_vld), .done(b_done)
  );

  // Expected per-cycle outputs of one frame, each bit held for 'hold' cycles.
  task automatic push_frame(input logic [W-1:0] w, input bit msb, input bit frm, input int hold);
    logic b;
    if (frm) repeat (hold) sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < W; i++) begin
      b = msb ? w[W-1-i] : w[i];
      repeat (hold) sb.push_back('{b, 1'b1, 1'b0, 1'b1});
    end
    if (frm) repeat (hold) sb.push_back('{1'b1, 1'b0, 1'b0, 1'b1});
    sb.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; load_b = 1'b1; pin = 4'hF; ce = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ready, a_busy, a_so, a_vld, a_done} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_a: ready/busy/so/vld/done=%b expected 10100", {a_ready, a_busy, a_so, a_vld, a_done});
    end
    checks++;
    if ({b_ready, b_busy, b_so, b_vld, b_done} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_b: ready/busy/so/vld/done=%b expected 10100", {b_ready, b_busy, b_so, b_vld, b_done});
    end
    rst = 1'b0; load = 1'b0; load_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ready, a_busy, a_so, a_vld, a_done} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_noframe_a: ready/busy/so/vld/done=%b expected 10100", {a_ready, a_busy, a_so, a_vld, a_done});
    end
    checks++;
    if ({b_ready, b_busy, b_so, b_vld, b_done} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_noframe_b: ready/busy/so/vld/done=%b expected 10100", {b_ready, b_busy, b_so, b_vld, b_done});
    end
  endtask

  task automatic test_framed_msb();
    exp_t e;
    int   n = 0;
    push_frame(4'b1011, 1'b1, 1'b1, 1);
    pin = 4'b1011; load = 1'b1; ce = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n++;
      checks++;
      if ({a_so, a_vld, a_done, a_busy, a_ready} !== {e, ~e.busy}) begin
        errors++;
        $display("FAIL framed_msb cycle %0d: so/vld/done/busy/ready=%b expected %b", n, {a_so, a_vld, a_done, a_busy, a_ready}, {e, ~e.busy});
      end
      @(negedge clk);
    end
    checks++;
    if (a_done !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL framed_msb_after: done=%b ready=%b expected done=0 ready=1", a_done, a_ready);
    end
  endtask

  task automatic test_lsb_unframed();
    exp_t e;
    int   n = 0;
    push_frame(4'b0001, 1'b0, 1'b0, 1);
    pin = 4'b0001; load_b = 1'b1; ce = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n++;
      checks++;
      if ({b_so, b_vld, b_done, b_busy, b_ready} !== {e, ~e.busy}) begin
        errors++;
        $display("FAIL lsb_unframed cycle %0d: so/vld/done/busy/ready=%b expected %b", n, {b_so, b_vld, b_done, b_busy, b_ready}, {e, ~e.busy});
      end
      @(negedge clk);
    end
    checks++;
    if (b_done !== 1'b0) begin
      errors++;
      $display("FAIL lsb_done_single: done=%b expected 0", b_done);
    end
  endtask

  task automatic test_ce_stall();
    exp_t e;
    int   c = 0;
    push_frame(4'b0110, 1'b1, 1'b1, 3);
    pin = 4'b0110; load = 1'b1; ce = 1'b0;
    @(negedge clk);
    load = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      c++;
      checks++;
      if ({a_so, a_vld, a_done, a_busy, a_ready} !== {e, ~e.busy}) begin
        errors++;
        $display("FAIL ce_stall cycle %0d: so/vld/done/busy/ready=%b expected %b", c, {a_so, a_vld, a_done, a_busy, a_ready}, {e, ~e.busy});
      end
      ce = (c % 3 == 0);
      @(negedge clk);
    end
    ce = 1'b1;
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL ce_stall_done_single: done=%b expected 0", a_done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   idx = 0;
    bit   saw_done = 1'b0;
    push_frame(4'b1001, 1'b1, 1'b1, 1);
    push_frame(4'b0110, 1'b1, 1'b1, 1);
    pin = 4'b1001; load = 1'b1; ce = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idx++;
      checks++;
      if ({a_so, a_vld, a_done, a_busy, a_ready} !== {e, ~e.busy}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: so/vld/done/busy/ready=%b expected %b", idx, {a_so, a_vld, a_done, a_busy, a_ready}, {e, ~e.busy});
      end
      load = 1'b0;
      if (idx == 3) begin
        load = 1'b1;
        pin  = 4'b0110;
      end
      if (idx == 4) pin = 4'b0000;
      if (e.done && !saw_done) begin
        saw_done = 1'b1;
        load = 1'b1;
        pin  = 4'b0110;
      end
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_end: busy=%b done=%b expected 0 0", a_busy, a_done);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int   n = 0;
    int   stray_done = 0;
    pin = 4'b1011; load = 1'b1; ce = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if ({a_so, a_busy} !== 2'b01) begin
      errors++;
      $display("FAIL abort_start: so/busy=%b expected 01", {a_so, a_busy});
    end
    @(negedge clk);
    checks++;
    if ({a_so, a_vld} !== 2'b11) begin
      errors++;
      $display("FAIL abort_data0: so/vld=%b expected 11", {a_so, a_vld});
    end
    @(negedge clk);
    checks++;
    if ({a_so, a_vld} !== 2'b01) begin
      errors++;
      $display("FAIL abort_data1: so/vld=%b expected 01", {a_so, a_vld});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_so, a_busy, a_ready, a_vld, a_done} !== 5'b10100) begin
      errors++;
      $display("FAIL abort_idle: so/busy/ready/vld/done=%b expected 10100", {a_so, a_busy, a_ready, a_vld, a_done});
    end
    repeat (8) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_busy !== 1'b0) stray_done++;
    end
    checks++;
    if (stray_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d cycles with done/busy set, expected 0", stray_done);
    end
    push_frame(4'b1111, 1'b1, 1'b1, 1);
    pin = 4'b1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n++;
      checks++;
      if ({a_so, a_vld, a_done, a_busy, a_ready} !== {e, ~e.busy}) begin
        errors++;
        $display("FAIL abort_reload cycle %0d: so/vld/done/busy/ready=%b expected %b", n, {a_so, a_vld, a_done, a_busy, a_ready}, {e, ~e.busy});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_framed_msb();
    test_lsb_unframed();
    test_ce_stall();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It captures a WIDTH-bit parallel word and shifts it out one bit per enabled clock on a single serial line.
- Optional start/stop framing around the data bits.
- Serves as the sending end of the team's parallel register datapath: words held in parallel registers are handed to this block and serialised for a downstream serial-in receiver.

Parameters:
- WIDTH, 4, number of data bits per word (>=2).
- MSB_FIRST, 1, 1 = shift pin[WIDTH-1] first; 0 = shift pin[0] first.
- FRAME, 1, 1 = emit one start bit (0) before the data and one stop bit (1) after it; 0 = data bits only.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- ce  input  1  shift enable (bit-rate tick); the state machine advances only on edges where ce=1.
- load  input  1  request to transmit pin; accepted only when ready=1.
- pin  input  WIDTH  parallel data word.
- ready  output  1  high when in IDLE and able to accept load.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- so  output  1  serial output line; idles high.
- so_valid  output  1  high only while so carries a data bit.
- done  output  1  single-cycle pulse on return to IDLE after a completed frame.

Behaviour:
- Reset (rst=1 at a rising edge, regardless of state):
  - state=IDLE, shift register=0, bit counter=0.
  - ready=1, busy=0, so=1, so_valid=0, done=0.
  - Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, START, DATA, STOP. All outputs are registered or decoded purely from state and shift register; no combinational path from inputs to outputs.
- IDLE:
  - ready=1, so=1.
  - On an edge with load=1, pin is captured into the shift register and the counter is cleared. This happens irrespective of ce.
  - Next state is START if FRAME=1, else DATA.
  - load=0 keeps the block in IDLE.
- START (FRAME=1 only):
  - so=0.
  - On an edge with ce=1, go to DATA. With ce=0, hold.
- DATA:
  - so = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]; so_valid=1.
  - On each edge with ce=1: shift the register by one toward the output end (fill 0) and increment the counter.
  - When the counter reaches WIDTH-1 on a ce edge (last bit sent), go to STOP if FRAME=1, else IDLE.
  - Exactly WIDTH data bits are emitted, each held for one ce period.
- STOP:
  - so=1.
  - On an edge with ce=1, go to IDLE.
- done pulses high for exactly one clk cycle: the first cycle back in IDLE after the final bit (stop bit, or last data bit when FRAME=0).
- Latency with ce held at 1:
  - load accepted at edge k; start bit on so during cycle k+1.
  - Data bits during cycles k+2 .. k+WIDTH+1; stop bit during cycle k+WIDTH+2.
  - done=1 and ready=1 during cycle k+WIDTH+3.
  - With FRAME=0, everything shifts one cycle earlier.
- Boundary conditions:
  - load while busy=1 is ignored. pin and load changes during a frame do not affect the frame in progress.
  - load asserted in the same cycle done=1 is accepted, giving back-to-back frames with one idle cycle (so=1) between them.
  - ce=0 stalls the FSM and holds so at its current value indefinitely.
  - rst and load in the same cycle: rst wins, load is dropped.
  - The counter width is clog2(WIDTH) and the counter never wraps within a frame.

Test Plan:
- Reset: rst=1 for 2 cycles, with load=1 and pin=4'hF during reset -> ready=1, busy=0, so=1, so_valid=0, done=0; no frame starts.
- Framed MSB-first, WIDTH=4, ce=1: load pin=4'b1011 -> so sequence 0,1,0,1,1,1 over 6 cycles; so_valid high for exactly cycles 2-5; done pulses once, 7 cycles after the load edge.
- LSB-first, FRAME=0: load pin=4'b0001 -> so = 1,0,0,0 immediately after the load edge; done one cycle after the last bit.
- ce stall: framed, pin=4'b0110, with ce=1 every 3rd cycle -> each bit held for 3 cycles; serial bit order unchanged; done after the stop bit's ce edge.
- Busy guard: load pin=4'b1001, then pulse load with pin=4'b0110 mid-frame -> the output frame is 1001 only. Re-assert load in the done cycle with 4'b0110 -> second frame 0,0,1,1,0,1 starts after one idle-high cycle.
- Abort: assert rst during the second data bit -> next cycle so=1, busy=0, ready=1, no done pulse. A subsequent load of 4'b1111 transmits 0,1,1,1,1,1 correctly.
